// File: rtl/scrambler_pkg.sv
// Shared constants and types for the x^58 + x^39 + 1 TX scrambler.
package scrambler_pkg;

    localparam int unsigned SCR_LEN = 58;
    localparam int unsigned SCR_TAP = 39;

    typedef logic [SCR_LEN-1:0] scr_state_t;

    localparam scr_state_t SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF;

endpackage : scrambler_pkg

// File: rtl/scrambler_lfsr_step.sv
// One unrolled step of the self-synchronous scrambler: scrambles WIDTH bits
// (bit 0 first) and returns the LFSR state after the last bit.
module scrambler_lfsr_step
    import scrambler_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  scr_state_t       state_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] scr_o,
    output scr_state_t       next_state_o
);

    // History = {scrambled bits, previous state}; each new bit feeds back on
    // bits scrambled earlier in the same word.
    always_comb begin : p_step
        logic [WIDTH+SCR_LEN-1:0] hist;
        hist              = '0;
        hist[SCR_LEN-1:0] = state_i;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            hist[SCR_LEN+i] = data_i[i] ^ hist[SCR_LEN+i-SCR_TAP] ^ hist[i];
        end
        scr_o        = hist[WIDTH+SCR_LEN-1:SCR_LEN];
        next_state_o = hist[WIDTH+SCR_LEN-1:WIDTH];
    end

endmodule : scrambler_lfsr_step

// File: rtl/scrambler_tx.sv
// Transmit scrambler with valid/ready on both sides and a one-entry skid
// stage so that in_ready is registered. Words are scrambled at accept time.
// Optional feature: define SCRAMBLER_TX_BYPASS_EN to add a per-word bypass
// input that passes data through unscrambled without advancing the LFSR.
module scrambler_tx
    import scrambler_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned HDR_W = 2,
    localparam int unsigned HW   = (HDR_W > 0) ? HDR_W : 1
) (
    input  logic             clk,
    input  logic             srst,
`ifdef SCRAMBLER_TX_BYPASS_EN
    input  logic             bypass,
`endif
    input  logic [WIDTH-1:0] in_data,
    input  logic [HW-1:0]    in_hdr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [HW-1:0]    out_hdr,
    output logic             out_valid,
    input  logic             out_ready
);

    scr_state_t       state_q, state_d;
    scr_state_t       step_state_c;
    logic [WIDTH-1:0] scr_word_c;
    logic [WIDTH-1:0] word_c;
    scr_state_t       adv_state_c;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [HW-1:0]    out_hdr_q, out_hdr_d;

    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [HW-1:0]    skid_hdr_q, skid_hdr_d;

    logic             in_ready_q, in_ready_d;
    logic             accept_c;
    logic             drain_c;

    scrambler_lfsr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .state_i      (state_q),
        .data_i       (in_data),
        .scr_o        (scr_word_c),
        .next_state_o (step_state_c)
    );

    // Select the word and state that an accept produces.
`ifdef SCRAMBLER_TX_BYPASS_EN
    always_comb begin
        word_c      = bypass ? in_data : scr_word_c;
        adv_state_c = bypass ? state_q : step_state_c;
    end
`else
    always_comb begin
        word_c      = scr_word_c;
        adv_state_c = step_state_c;
    end
`endif

    // Handshake, skid and LFSR next-state logic.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_hdr_d    = out_hdr_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_hdr_d   = skid_hdr_q;

        accept_c = in_valid && in_ready_q;
        drain_c  = out_valid_q && out_ready;

        if (accept_c) begin
            state_d = adv_state_c;
        end

        if (skid_valid_q) begin
            // in_ready is low while skid is full, so only a drain can happen
            if (drain_c) begin
                out_data_d   = skid_data_q;
                out_hdr_d    = skid_hdr_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            if (!out_valid_q || drain_c) begin
                out_data_d  = word_c;
                out_hdr_d   = in_hdr;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d  = word_c;
                skid_hdr_d   = in_hdr;
                skid_valid_d = 1'b1;
            end
        end else if (drain_c) begin
            out_valid_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= SCR_SEED;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_hdr_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_hdr_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_hdr_q    <= out_hdr_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_hdr_q   <= skid_hdr_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_hdr   = out_hdr_q;

endmodule : scrambler_tx

// File: tb/tb_scrambler_tx.sv
// Self-checking bench for scrambler_tx (WIDTH=64, HDR_W=2) using a bit-serial
// reference scrambler, a scoreboard queue and a bit-serial descrambler.
module tb_scrambler_tx;

    localparam logic [63:0] FIRST_ZERO = 64'h03FF_FF80_0000_0000;
    localparam logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        srst;
    logic        byp;
    logic [63:0] in_data;
    logic [1:0]  in_hdr;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [1:0]  out_hdr;
    logic        out_valid;
    logic        out_ready;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  hdr;
        logic [63:0] plain;
        logic        byp;
    } exp_t;

    exp_t        sbq[$];
    logic [57:0] m_state;
    logic [57:0] d_state;
    int          total = 0;
    int          bad   = 0;
    int          n_out = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;

    scrambler_tx #(.WIDTH(64), .HDR_W(2)) dut (
        .clk       (clk),
        .srst      (srst),
`ifdef SCRAMBLER_TX_BYPASS_EN
        .bypass    (byp),
`endif
        .in_data   (in_data),
        .in_hdr    (in_hdr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_hdr   (out_hdr),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Serial reference: bit 0 first, taps at 39 and 58 bits back.
    function automatic void scr_ref(input logic [63:0] d, input logic [57:0] si,
                                    output logic [63:0] o, output logic [57:0] so);
        logic b;
        so = si;
        o  = '0;
        for (int i = 0; i < 64; i++) begin
            b    = d[i] ^ so[38] ^ so[57];
            o[i] = b;
            so   = {so[56:0], b};
        end
    endfunction

    function automatic void dscr_ref(input logic [63:0] c, input logic [57:0] si,
                                     output logic [63:0] p, output logic [57:0] so);
        so = si;
        p  = '0;
        for (int i = 0; i < 64; i++) begin
            p[i] = c[i] ^ so[38] ^ so[57];
            so   = {so[56:0], c[i]};
        end
    endfunction

    // Output monitor: pops the scoreboard on every transfer.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] p;
        if (srst) begin
            prev_stall = 1'b0;
            d_state    = SEED;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_hdr", 64'(out_hdr), 64'(e.hdr));
                    if (!e.byp) begin
                        dscr_ref(out_data, d_state, p, d_state);
                        check("loopback", p, e.plain);
                    end
                end
                n_out++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // One clock: record an accept (and its expected result), then advance.
    task automatic step(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready && !srst;
        if (acc) begin
            e.hdr   = in_hdr;
            e.plain = in_data;
            e.byp   = 1'b0;
`ifdef SCRAMBLER_TX_BYPASS_EN
            e.byp   = byp;
`endif
            if (e.byp) e.data = in_data;
            else scr_ref(in_data, m_state, e.data, m_state);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [1:0] h, input logic b);
        bit acc;
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_hdr   = h;
        byp      = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            step(acc);
            done = acc;
        end
        in_valid = 1'b0;
        check("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic drain();
        bit acc;
        bit done;
        done      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            step(acc);
            done = (sbq.size() == 0) && !out_valid;
        end
        check("drain_timeout", 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        bit acc;
        srst     = 1'b1;
        in_valid = 1'b0;
        sbq.delete();
        m_state  = SEED;
        step(acc);
        step(acc);
        srst = 1'b0;
    endtask

    initial begin
        bit acc;
        int accepted;
        int drops;
        int n0;
        in_data   = '0;
        in_hdr    = '0;
        byp       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        m_state   = SEED;
        #1;
        do_reset();

        // reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_hdr", 64'(out_hdr), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // first zero word after reset, then a second zero word
        send(64'd0, 2'b01, 1'b0);
        check("w1_valid", 64'(out_valid), 64'd1);
        check("w1_data", out_data, FIRST_ZERO);
        send(64'd0, 2'b10, 1'b0);
        check("w2_nonzero", 64'(out_data != 64'd0), 64'd1);
        check("w2_differs", 64'(out_data != FIRST_ZERO), 64'd1);
        drain();

        // backpressure: stream 0,1,2,... with a 3-cycle stall
        n0 = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_data   = 64'(n0);
            in_hdr    = 2'(n0);
            out_ready = !(c >= 5 && c < 8);
            if (c == 7) check("stall_in_ready", 64'(in_ready), 64'd0);
            step(acc);
            if (acc) n0++;
        end
        drain();

        // full throughput
        accepted = 0;
        drops    = 0;
        n0       = n_out;
        in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_data = {$urandom, $urandom};
            in_hdr  = 2'($urandom);
            if (!in_ready) drops++;
            step(acc);
            if (acc) accepted++;
        end
        drain();
        check("tput_accepted", 64'(accepted), 64'd100);
        check("tput_ready_drops", 64'(drops), 64'd0);
        check("tput_out_count", 64'(n_out - n0), 64'd100);

        // random traffic with random backpressure
        in_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(3) != 0);
                in_data  = {$urandom, $urandom};
                in_hdr   = 2'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
            step(acc);
        end
        drain();

        // reset with skid full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n0        = 0;
        for (int k = 0; k < 10 && n0 < 2; k++) begin
            in_data = {$urandom, $urandom};
            step(acc);
            if (acc) n0++;
        end
        in_valid = 1'b0;
        check("skid_full_ready", 64'(in_ready), 64'd0);
        srst = 1'b1;
        sbq.delete();
        m_state = SEED;
        step(acc);
        srst = 1'b0;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send(64'd0, 2'b11, 1'b0);
        check("mid_rst_first", out_data, FIRST_ZERO);
        drain();

`ifdef SCRAMBLER_TX_BYPASS_EN
        do_reset();
        send(64'hDEAD_BEEF_0123_4567, 2'b01, 1'b1);
        check("bypass_word", out_data, 64'hDEAD_BEEF_0123_4567);
        send(64'd0, 2'b10, 1'b0);
        check("after_bypass", out_data, FIRST_ZERO);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_scrambler_tx
